up_down_counter_sched: RTL and testbench
========================================

# up_down_counter_sched

Job scheduler and round-robin arbiter that shares one `up_down_counter` instance among `N_REQ` requesters. Each requester submits a count job (start value, end value, direction) over a valid/ready handshake. The scheduler programs the counter, runs it to completion and returns the final count and status to the requester on a single response channel. It sits directly in front of the counter and is the only block that drives its control inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)`: width of the requester index.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in RUN. Used only when `CNT_SCHED_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester job valid.
- `req_ready` out `N_REQ`: per-requester accept, one-hot or zero.
- `req_start_val` in `N_REQ`x32: packed start values, requester i at `[32*i +: 32]`.
- `req_end_val` in `N_REQ`x32: packed end values.
- `req_direction` in `N_REQ` x `direction_t`: per-requester direction.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response accept.
- `resp_id` out `ID_W`: index of the requester that owns the response.
- `resp_status` out `status_t`: final counter status, DONE or ERROR.
- `resp_err` out `err_t`: final counter error code.
- `resp_cnt` out 32: final counter value.
- `busy` out 1: high in every state except IDLE.
- `cnt_en`, `cnt_clear` out 1: drive the counter's `en` and `clear`.
- `cnt_direction` out `direction_t`: drives the counter's `direction`.
- `cnt_start_val`, `cnt_end_val` out 32: drive the counter's start and end values.
- `cnt_status` in `status_t`, `cnt_error_status` in `err_t`, `cnt_cnt` in 32: counter outputs.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP (plus ABORT when the macro is defined).
- **IDLE**
  - Round-robin grant `g` is computed combinationally from `req_valid`.
  - Search starts at `rr_ptr`, then wraps upward.
  - `req_ready[g]=1` only while `req_valid[g]=1`.
  - On the handshake, the job is latched into the `cnt_*` registers and `resp_id<=g`, then the FSM moves to LOAD.
  - With no valid requester, the FSM stays in IDLE with all `req_ready` low.
- **LOAD**: `cnt_clear=1` and `cnt_en=0` for exactly one cycle, then RUN.
- **RUN**
  - `cnt_en=1` and `cnt_clear=0`.
  - When `cnt_status` is DONE or ERROR, capture `cnt_cnt`, `cnt_status` and `cnt_error_status` into `resp_*`, then move to RESP.
  - Any other status keeps the FSM in RUN.
- **RESP**
  - `cnt_en=0` and `resp_valid=1`; `resp_*` is held stable until `resp_ready`.
  - On the handshake: `rr_ptr<=g+1`, wrapping to 0 after `N_REQ-1`, then IDLE.
- `cnt_direction`, `cnt_start_val` and `cnt_end_val` hold constant from LOAD through RESP. Requester inputs are don't-care after acceptance.
- A requester with no grant keeps `req_valid` high. Jobs are never dropped.
- Only one job is in flight; no new grant is issued until the response handshake completes.
- The scheduler does not check jobs itself. An UP job with start > end returns ERROR/UP_ERR, and a DOWN job with start < end returns ERROR/DOWN_ERR, both as reported by the counter.

## Timing
- Reset values:
  - FSM=IDLE, `rr_ptr=0`.
  - `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_status=READY`, `resp_err` = no-error value, `resp_cnt=0`.
  - `busy=0`, `cnt_en=0`, `cnt_clear=1`, `cnt_direction=default_dir`, `cnt_start_val=0`, `cnt_end_val=0`.
- Reset asserted mid-job forces all of the above immediately. The job is lost and no response is produced.
- Job cycle sequence:
  - Request handshake at edge T.
  - `cnt_clear` high in cycle T+1.
  - `cnt_en` high from T+2.
  - Terminal status sampled at edge S sets `resp_valid` in cycle S+1.
  - `cnt_en` is low in cycle S+1.
- Minimum issue-to-issue spacing is 4 cycles, with `resp_ready` tied high and an immediate terminal status.
- If `req_valid` and the response handshake occur in the same cycle, the grant is issued in the following cycle, not the same one.

## Configuration
- `CNT_SCHED_TIMEOUT_EN` defined:
  - A 32-bit watchdog counts cycles in RUN.
  - When it reaches `TIMEOUT_CYCLES` with no terminal status, the FSM enters ABORT.
  - ABORT asserts `cnt_clear` for one cycle, then enters RESP with `resp_status=ERROR`, `resp_err` = the timeout code, `resp_cnt=cnt_cnt`.
- Not defined: no watchdog and no ABORT state; RUN waits indefinitely.

## Structure
- `custom_package` supplies `direction_t`, `status_t` and `err_t`.
- The timeout `err_t` member is added to `err_t` there.
- The FSM state enum `sched_state_t` is also added to `custom_package`.
- Sub-module `rr_arbiter` (parameter `N`) takes `req`, `ptr` and returns one-hot `gnt` plus `gnt_idx`. It is purely combinational and instantiated once.

## Test plan
- Reset: hold `rst_n=0` for 5 cycles -> `busy=0`, `cnt_clear=1`, `cnt_en=0`, `resp_valid=0`, all `req_ready=0`.
- Req0 UP 0->10 -> one `req_ready[0]` pulse, one-cycle `cnt_clear`, then the response with `resp_id=0`, DONE, `resp_cnt=10`.
- Req2 UP 10->5 -> response with `resp_id=2`, ERROR, UP_ERR.
- Req1 DOWN 10->4 with `resp_ready` held low 3 cycles -> `resp_*` stable throughout, then `resp_cnt=4`, DONE.
- Req0 and req1 both valid continuously -> grant order 0,1,0,1; no grant while `busy`.
- Mid-RUN `rst_n` pulse -> immediate reset values, no response. With `CNT_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES=8` on a stalled counter -> ERROR/timeout response.

Source files
------------

// File: rtl/up_down_counter_sched_pkg.sv
// Shared types for the up_down_counter and its job scheduler: direction, status,
// error codes and the scheduler state encoding.
package custom_package;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } direction_t;

    typedef enum logic [1:0] {
        READY,
        RUNNING,
        DONE,
        ERROR
    } status_t;

    typedef enum logic [1:0] {
        NO_ERR,
        UP_ERR,
        DOWN_ERR,
        TIMEOUT_ERR
    } err_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RESP,
        ABORT
    } sched_state_t;

    localparam direction_t default_dir = UP;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr, wrapping upward; one-hot gnt plus its index.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic        found;
    logic [W-1:0] pos;
    int unsigned sum;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        sum     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always below N, so a single subtract wraps the search
            sum = 32'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = W'(sum);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/up_down_counter_sched.sv
// Round-robin job scheduler sharing one up_down_counter among N_REQ requesters.
// Define CNT_SCHED_TIMEOUT_EN to add the RUN watchdog and the ABORT state.
module up_down_counter_sched
    import custom_package::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ID_W           = $clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [32*N_REQ-1:0]    req_start_val,
    input  logic [32*N_REQ-1:0]    req_end_val,
    input  direction_t [N_REQ-1:0] req_direction,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output status_t                resp_status,
    output err_t                   resp_err,
    output logic [31:0]            resp_cnt,
    output logic                   busy,
    output logic                   cnt_en,
    output logic                   cnt_clear,
    output direction_t             cnt_direction,
    output logic [31:0]            cnt_start_val,
    output logic [31:0]            cnt_end_val,
    input  status_t                cnt_status,
    input  err_t                   cnt_error_status,
    input  logic [31:0]            cnt_cnt
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("up_down_counter_sched: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("up_down_counter_sched: TIMEOUT_CYCLES must be nonzero");
    end

    sched_state_t      state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, gnt_idx;
    logic [N_REQ-1:0]  gnt;
    logic              terminal;

    rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign terminal   = (cnt_status == DONE) || (cnt_status == ERROR);
    assign rr_ptr_nxt = (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + 1'b1;

`ifdef CNT_SCHED_TIMEOUT_EN
    logic [31:0] wdog;
    logic        timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == RUN) begin
            wdog <= wdog + 32'd1;
        end else begin
            wdog <= '0;
        end
    end

    assign timeout = (state == RUN) && (wdog == TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (terminal) begin
                    state_nxt = RESP;
                end
`ifdef CNT_SCHED_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = ABORT;
                end
`endif
            end
`ifdef CNT_SCHED_TIMEOUT_EN
            ABORT: state_nxt = RESP;
`endif
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter controls are registered from the next state so they are glitch-free
    // and still line up with LOAD/RUN/ABORT cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            resp_id       <= '0;
            resp_status   <= READY;
            resp_err      <= NO_ERR;
            resp_cnt      <= '0;
            cnt_en        <= 1'b0;
            cnt_clear     <= 1'b1;
            cnt_direction <= default_dir;
            cnt_start_val <= '0;
            cnt_end_val   <= '0;
        end else begin
            cnt_en    <= (state_nxt == RUN);
            cnt_clear <= (state_nxt == LOAD) || (state_nxt == ABORT);
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        resp_id       <= gnt_idx;
                        cnt_direction <= req_direction[gnt_idx];
                        cnt_start_val <= req_start_val[32*gnt_idx +: 32];
                        cnt_end_val   <= req_end_val[32*gnt_idx +: 32];
                    end
                end
                RUN: begin
                    if (terminal) begin
                        resp_cnt    <= cnt_cnt;
                        resp_status <= cnt_status;
                        resp_err    <= cnt_error_status;
                    end
`ifdef CNT_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        resp_cnt    <= cnt_cnt;
                        resp_status <= ERROR;
                        resp_err    <= TIMEOUT_ERR;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= rr_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_up_down_counter_sched.sv
// Self-checking bench for up_down_counter_sched with a behavioural counter model
// and a response scoreboard.
module tb_up_down_counter_sched;
    import custom_package::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [32*N-1:0]     req_start_val;
    logic [32*N-1:0]     req_end_val;
    direction_t [N-1:0]  req_direction;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    status_t             resp_status;
    err_t                resp_err;
    logic [31:0]         resp_cnt;
    logic                busy;
    logic                cnt_en;
    logic                cnt_clear;
    direction_t          cnt_direction;
    logic [31:0]         cnt_start_val;
    logic [31:0]         cnt_end_val;
    status_t             cnt_status;
    err_t                cnt_error_status;
    logic [31:0]         cnt_cnt;

    up_down_counter_sched #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_start_val    (req_start_val),
        .req_end_val      (req_end_val),
        .req_direction    (req_direction),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_id          (resp_id),
        .resp_status      (resp_status),
        .resp_err         (resp_err),
        .resp_cnt         (resp_cnt),
        .busy             (busy),
        .cnt_en           (cnt_en),
        .cnt_clear        (cnt_clear),
        .cnt_direction    (cnt_direction),
        .cnt_start_val    (cnt_start_val),
        .cnt_end_val      (cnt_end_val),
        .cnt_status       (cnt_status),
        .cnt_error_status (cnt_error_status),
        .cnt_cnt          (cnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter: one step per enabled cycle, flags DONE/ERROR one cycle later.
    logic stall;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cnt <= '0; cnt_status <= READY; cnt_error_status <= NO_ERR;
        end else if (cnt_clear) begin
            cnt_cnt <= cnt_start_val; cnt_status <= READY; cnt_error_status <= NO_ERR;
        end else if (cnt_en && !stall && cnt_status != DONE && cnt_status != ERROR) begin
            if (cnt_direction == UP && cnt_start_val > cnt_end_val) begin
                cnt_status <= ERROR; cnt_error_status <= UP_ERR;
            end else if (cnt_direction == DOWN && cnt_start_val < cnt_end_val) begin
                cnt_status <= ERROR; cnt_error_status <= DOWN_ERR;
            end else if (cnt_cnt == cnt_end_val) begin
                cnt_status <= DONE;
            end else begin
                cnt_status <= RUNNING;
                cnt_cnt    <= (cnt_direction == UP) ? cnt_cnt + 32'd1 : cnt_cnt - 32'd1;
            end
        end
    end

    typedef struct {
        int unsigned id;
        direction_t  dir;
        logic [31:0] sv;
        logic [31:0] ev;
        status_t     st;
        err_t        er;
        logic [31:0] cnt;
    } job_t;

    job_t pend [N];
    job_t sb [$];
    int   grant_log [$];
    int   grant_cyc [$];
    int   cyc;
    int   checks;
    int   errors;
    job_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                chk("ready_while_busy", 32'(busy), 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(pend[i]);
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
            if (resp_valid) chk("en_low_in_resp", 32'(cnt_en), 32'd0);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual_id=%0d required=none", resp_id);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_id", 32'(resp_id), mon_e.id);
                    chk("resp_status", 32'(resp_status), 32'(mon_e.st));
                    chk("resp_err", 32'(resp_err), 32'(mon_e.er));
                    chk("resp_cnt", resp_cnt, mon_e.cnt);
                end
            end
        end
    end

    task automatic set_job(input job_t j);
        pend[j.id] = j;
        req_start_val[32*j.id +: 32] = j.sv;
        req_end_val[32*j.id +: 32]   = j.ev;
        req_direction[j.id]          = j.dir;
    endtask

    task automatic issue(input job_t j);
        bit got;
        got = 1'b0;
        set_job(j);
        @(posedge clk); #1;
        req_valid[j.id] = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = req_ready[j.id];
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[j.id] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (sb.size() == 0) && !busy;
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    job_t vec [7];
    job_t j;
    bit   seen;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1; stall = 1'b0;
        req_start_val = '0; req_end_val = '0; req_direction = '0;

        vec[0] = '{1, UP,   32'd3,         32'd7,         DONE,  NO_ERR,   32'd7};
        vec[1] = '{2, UP,   32'd10,        32'd5,         ERROR, UP_ERR,   32'd10};
        vec[2] = '{3, DOWN, 32'd9,         32'd2,         DONE,  NO_ERR,   32'd2};
        vec[3] = '{0, DOWN, 32'd1,         32'd6,         ERROR, DOWN_ERR, 32'd1};
        vec[4] = '{3, UP,   32'hFFFF_FFFC, 32'hFFFF_FFFF, DONE,  NO_ERR,   32'hFFFF_FFFF};
        vec[5] = '{2, DOWN, 32'd4,         32'd4,         DONE,  NO_ERR,   32'd4};
        vec[6] = '{1, UP,   32'd0,         32'd0,         DONE,  NO_ERR,   32'd0};

        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clear", 32'(cnt_clear), 32'd1);
        chk("rst_en", 32'(cnt_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_status", 32'(resp_status), 32'(READY));
        chk("rst_resp_cnt", resp_cnt, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Request 0 UP 0->10 with cycle-level control checks.
        j = '{0, UP, 32'd0, 32'd10, DONE, NO_ERR, 32'd10};
        set_job(j);
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        #1 chk("ready0_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("load_clear", 32'(cnt_clear), 32'd1);
        chk("load_en", 32'(cnt_en), 32'd0);
        chk("load_ready", 32'(req_ready), 32'd0);
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("run_clear", 32'(cnt_clear), 32'd0);
        chk("run_en", 32'(cnt_en), 32'd1);
        chk("run_start_held", cnt_start_val, 32'd0);
        drain();

        for (int k = 0; k < 7; k++) begin
            issue(vec[k]);
            drain();
        end

        // Response back-pressure: resp_* must hold while resp_ready is low.
        resp_ready = 1'b0;
        issue('{1, DOWN, 32'd10, 32'd4, DONE, NO_ERR, 32'd4});
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        if (!seen) chk("hold_resp_timeout", 32'd0, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_cnt", resp_cnt, 32'd4);
            chk("hold_id", 32'(resp_id), 32'd1);
            chk("hold_status", 32'(resp_status), 32'(DONE));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drain();

        // Two requesters contending; rr_ptr is 2 here so the search reaches 0 first.
        set_job('{0, UP,   32'd5, 32'd5, DONE, NO_ERR, 32'd5});
        set_job('{1, DOWN, 32'd7, 32'd7, DONE, NO_ERR, 32'd7});
        grant_log.delete();
        grant_cyc.delete();
        @(posedge clk); #1;
        req_valid[1:0] = 2'b11;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            seen = (grant_log.size() >= 4);
        end
        req_valid[1:0] = 2'b00;
        if (!seen) chk("rr_timeout", 32'd0, 32'd1);
        drain();
        chk("rr_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            chk("rr_order", 32'(grant_log[k]), 32'(k % 2));
        end
        // One extra cycle per job because the model counter flags DONE a cycle after enable.
        for (int k = 1; k < 4 && k < grant_cyc.size(); k++) begin
            chk("rr_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd5);
        end

        // Reset in the middle of a RUN: job is dropped, no response.
        issue('{3, UP, 32'd0, 32'd20, DONE, NO_ERR, 32'd20});
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_clear", 32'(cnt_clear), 32'd1);
        chk("mrst_en", 32'(cnt_en), 32'd0);
        chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mrst_resp_id", 32'(resp_id), 32'd0);
        chk("mrst_start", cnt_start_val, 32'd0);
        chk("mrst_end", cnt_end_val, 32'd0);
        chk("mrst_dir", 32'(cnt_direction), 32'(UP));
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        issue('{1, UP, 32'd2, 32'd4, DONE, NO_ERR, 32'd4});
        drain();

`ifdef CNT_SCHED_TIMEOUT_EN
        stall = 1'b1;
        issue('{2, UP, 32'd3, 32'd9, ERROR, TIMEOUT_ERR, 32'd3});
        drain();
        stall = 1'b0;
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

endmodule
